// File: rtl/regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// regfile_scoreboard
//
// Decode-stage register file with NRD combinational read ports, one
// synchronous write port and a per-register in-flight counter scoreboard.
// The counters track how many issued writers to each register have not yet
// retired. They drive issue back-pressure (issue_ready) and per-port
// busy/stall flags for the operands consumed in ID.
//
// Optional feature macro: RF_WRITE_BYPASS_EN
//   defined   - a same-cycle writeback is forwarded onto rdata, and a port
//               whose only outstanding producer is retiring this cycle is
//               not reported busy.
//   undefined - rdata always returns stored contents, and rbusy = cnt != 0.
//
// Ports:
//   clk, reset         rising-edge clock, synchronous active-high reset
//   raddr / rused      NRD packed read addresses / port-consumed flags
//   rdata / rzero      NRD packed read data / "nonzero address reads zero"
//   rbusy / stall      per-port outstanding producer / |(rbusy & rused)
//   we, waddr, wdata   writeback port
//   ro_data            value returned for the write-protected RO_REG
//   issue_en, issue_rd, issue_ready   destination allocation and back-pressure
//   cancel_en, cancel_rd              retirement of a writer that does not write
//   sb_err             sticky scoreboard underflow/overflow error
// -----------------------------------------------------------------------------
module regfile_scoreboard #(
    parameter int DATA_W = 32,
    parameter int AW     = 5,
    parameter int NRD    = 3,
    parameter int RO_REG = 30,
    parameter int CNT_W  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NRD*AW-1:0]     raddr,
    input  logic [NRD-1:0]        rused,
    output logic [NRD*DATA_W-1:0] rdata,
    output logic [NRD-1:0]        rzero,
    output logic [NRD-1:0]        rbusy,
    output logic                  stall,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W-1:0]     ro_data,
    input  logic                  issue_en,
    input  logic [AW-1:0]         issue_rd,
    output logic                  issue_ready,
    input  logic                  cancel_en,
    input  logic [AW-1:0]         cancel_rd,
    output logic                  sb_err
);

    localparam int NREG = 2 ** AW;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [DATA_W-1:0] regs_reg [NREG];
    logic [CNT_W-1:0]  cnt_reg  [NREG];
    logic [CNT_W-1:0]  cnt_next [NREG];
    logic [NREG-1:0]   uflow;
    logic              sb_err_reg;

    // Register 0 is hard-wired zero and RO_REG mirrors ro_data; neither is
    // stored, written or tracked by the scoreboard.
    function automatic logic writable(input logic [AW-1:0] a);
        return (a != '0) && (a != AW'(RO_REG));
    endfunction

    // Saturated destinations refuse new issues; untracked registers never do.
    assign issue_ready = !writable(issue_rd) || (cnt_reg[issue_rd] != CNT_MAX);

    // ---------------------------------------------------------------------
    // Per-register counter next-state. A writeback and a cancel to the same
    // register in one cycle retire two producers. The sum is formed two bits
    // wider so a retire without a matching issue shows up as up < down and
    // clamps at zero instead of wrapping. Overflow cannot occur because inc
    // is already gated by issue_ready.
    // ---------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_cnt
            localparam bit WRITABLE = (gi != 0) && (gi != RO_REG);
            logic             inc;
            logic             dec_w;
            logic             dec_c;
            logic [CNT_W+1:0] up;
            logic [CNT_W+1:0] down;

            assign inc   = WRITABLE && issue_en && issue_ready && (issue_rd == AW'(gi));
            assign dec_w = WRITABLE && we && (waddr == AW'(gi));
            assign dec_c = WRITABLE && cancel_en && (cancel_rd == AW'(gi));
            assign up    = {2'b00, cnt_reg[gi]} + (CNT_W+2)'(inc);
            assign down  = (CNT_W+2)'(dec_w) + (CNT_W+2)'(dec_c);
            assign uflow[gi]    = (up < down);
            assign cnt_next[gi] = (up < down) ? '0 : CNT_W'(up - down);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs_reg[i] <= '0;
                cnt_reg[i]  <= '0;
            end
            sb_err_reg <= 1'b0;
        end else begin
            if (we && writable(waddr)) begin
                regs_reg[waddr] <= wdata;
            end
            for (int i = 0; i < NREG; i++) begin
                cnt_reg[i] <= cnt_next[i];
            end
            // Dropped issue (overflow attempt) or any counter underflow.
            if ((|uflow) || (issue_en && !issue_ready)) begin
                sb_err_reg <= 1'b1;
            end
        end
    end

    assign sb_err = sb_err_reg;

    // ---------------------------------------------------------------------
    // Read ports
    // ---------------------------------------------------------------------
    generate
        for (gi = 0; gi < NRD; gi++) begin : g_rd
            logic [AW-1:0]     rd_addr;
            logic [DATA_W-1:0] rd_data;
            logic [CNT_W-1:0]  rd_cnt;
            logic              rd_busy;

            assign rd_addr = raddr[gi*AW +: AW];
            assign rd_cnt  = cnt_reg[rd_addr];

            always_comb begin
                if (rd_addr == '0) begin
                    rd_data = '0;
                end else if (rd_addr == AW'(RO_REG)) begin
                    rd_data = ro_data;
`ifdef RF_WRITE_BYPASS_EN
                end else if (we && (waddr == rd_addr)) begin
                    rd_data = wdata;
`endif
                end else begin
                    rd_data = regs_reg[rd_addr];
                end
            end

            always_comb begin
                rd_busy = writable(rd_addr) && (rd_cnt != '0);
`ifdef RF_WRITE_BYPASS_EN
                // The last outstanding producer is being forwarded right now.
                if ((rd_cnt == CNT_W'(1)) && we && (waddr == rd_addr)) begin
                    rd_busy = 1'b0;
                end
`endif
            end

            assign rdata[gi*DATA_W +: DATA_W] = rd_data;
            assign rzero[gi] = (rd_addr != '0) && (rd_data == '0);
            assign rbusy[gi] = rd_busy;
        end
    endgenerate

    assign stall = |(rbusy & rused);

endmodule

// File: tb/tb_regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_regfile_scoreboard
//
// Directed testbench for regfile_scoreboard with default parameters
// (DATA_W=32, AW=5, NRD=3, RO_REG=30, CNT_W=2). Expected values are written
// by hand from the intended behaviour; bypass-dependent expectations follow
// the RF_WRITE_BYPASS_EN macro.
// -----------------------------------------------------------------------------
module tb_regfile_scoreboard;

    logic        clk;
    logic        reset;
    logic [14:0] raddr;
    logic [2:0]  rused;
    logic [95:0] rdata;
    logic [2:0]  rzero;
    logic [2:0]  rbusy;
    logic        stall;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] ro_data;
    logic        issue_en;
    logic [4:0]  issue_rd;
    logic        issue_ready;
    logic        cancel_en;
    logic [4:0]  cancel_rd;
    logic        sb_err;

    int checks_cnt = 0;
    int errors_cnt = 0;

    regfile_scoreboard dut (
        .clk         (clk),
        .reset       (reset),
        .raddr       (raddr),
        .rused       (rused),
        .rdata       (rdata),
        .rzero       (rzero),
        .rbusy       (rbusy),
        .stall       (stall),
        .we          (we),
        .waddr       (waddr),
        .wdata       (wdata),
        .ro_data     (ro_data),
        .issue_en    (issue_en),
        .issue_rd    (issue_rd),
        .issue_ready (issue_ready),
        .cancel_en   (cancel_en),
        .cancel_rd   (cancel_rd),
        .sb_err      (sb_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog: the run is purely directed, so this only trips on a hang.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Advance one clock; inputs are changed 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after an input change.
    task automatic settle();
        #1;
    endtask

    task automatic set_raddr(input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2);
        raddr = {a2, a1, a0};
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b0; raddr = '0; rused = '0; we = 1'b0; waddr = '0; wdata = '0;
        ro_data = 32'h1234; issue_en = 1'b0; issue_rd = '0; cancel_en = 1'b0; cancel_rd = '0;
        @(posedge clk);
        #1;

        // ---- reset state and basic reads ----
        do_reset();
        set_raddr(5'd0, 5'd5, 5'd30);
        rused = 3'b111;
        issue_rd = 5'd7;
        settle();
        check("rst_rdata0", rdata[31:0], 32'h0);
        check("rst_rdata1", rdata[63:32], 32'h0);
        check("rst_rdata2", rdata[95:64], 32'h1234);
        check("rst_rzero", 32'(rzero), 32'b010);
        check("rst_rbusy", 32'(rbusy), 32'b000);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_issue_ready", 32'(issue_ready), 32'd1);
        check("rst_sb_err", 32'(sb_err), 32'd0);

        // ---- RAW hazard on r7 resolved by writeback ----
        issue_en = 1'b1; issue_rd = 5'd7;
        tick();
        issue_en = 1'b0;
        set_raddr(5'd7, 5'd0, 5'd0);
        rused = 3'b001;
        settle();
        check("raw_rbusy0", 32'(rbusy[0]), 32'd1);
        check("raw_stall", 32'(stall), 32'd1);
        we = 1'b1; waddr = 5'd7; wdata = 32'hA5;
        settle();
`ifdef RF_WRITE_BYPASS_EN
        check("wb_rdata0_bypass", rdata[31:0], 32'hA5);
        check("wb_stall_bypass", 32'(stall), 32'd0);
`else
        check("wb_rdata0_nobypass", rdata[31:0], 32'h0);
        check("wb_stall_nobypass", 32'(stall), 32'd1);
`endif
        tick();
        we = 1'b0;
        settle();
        check("wb_rdata0_after", rdata[31:0], 32'hA5);
        check("wb_stall_after", 32'(stall), 32'd0);
        check("wb_rzero_after", 32'(rzero[0]), 32'd0);

        // ---- saturate r9, dropped fourth issue, drain ----
        issue_en = 1'b1; issue_rd = 5'd9;
        tick(); tick(); tick();
        settle();
        check("sat_issue_ready", 32'(issue_ready), 32'd0);
        check("sat_sb_err_before", 32'(sb_err), 32'd0);
        tick();
        issue_en = 1'b0;
        settle();
        check("sat_sb_err_drop", 32'(sb_err), 32'd1);
        set_raddr(5'd9, 5'd0, 5'd0);
        we = 1'b1; waddr = 5'd9; wdata = 32'h99;
        tick(); tick();
        we = 1'b0;
        settle();
        check("drain2_rbusy0", 32'(rbusy[0]), 32'd1);
        check("drain2_issue_ready", 32'(issue_ready), 32'd1);
        we = 1'b1;
        tick();
        we = 1'b0;
        settle();
        check("drain3_rbusy0", 32'(rbusy[0]), 32'd0);
        check("drain3_rdata0", rdata[31:0], 32'h99);

        // ---- simultaneous issue and writeback on r4 nets out ----
        issue_en = 1'b1; issue_rd = 5'd4;
        tick();
        we = 1'b1; waddr = 5'd4; wdata = 32'h44;
        tick();
        issue_en = 1'b0; we = 1'b0;
        set_raddr(5'd4, 5'd0, 5'd0);
        settle();
        check("net_rbusy0", 32'(rbusy[0]), 32'd1);
        check("net_rdata0", rdata[31:0], 32'h44);
        we = 1'b1;
        tick();
        we = 1'b0;
        settle();
        check("net_drain_rbusy0", 32'(rbusy[0]), 32'd0);

        // ---- non-writable targets are ignored; cancel underflow ----
        do_reset();
        we = 1'b1; waddr = 5'd0; wdata = 32'hFFFF;
        tick();
        waddr = 5'd30;
        tick();
        we = 1'b0;
        set_raddr(5'd0, 5'd30, 5'd3);
        issue_rd = 5'd30;
        settle();
        check("ro_rdata0", rdata[31:0], 32'h0);
        check("ro_rdata1", rdata[63:32], 32'h1234);
        check("ro_rbusy", 32'(rbusy), 32'b000);
        check("ro_issue_ready", 32'(issue_ready), 32'd1);
        check("ro_sb_err", 32'(sb_err), 32'd0);
        cancel_en = 1'b1; cancel_rd = 5'd3;
        tick();
        cancel_en = 1'b0;
        settle();
        check("uflow_sb_err", 32'(sb_err), 32'd1);
        check("uflow_rbusy2", 32'(rbusy[2]), 32'd0);

        // ---- writeback plus cancel on the same register retires two ----
        do_reset();
        check("rst2_sb_err", 32'(sb_err), 32'd0);
        issue_en = 1'b1; issue_rd = 5'd6;
        tick(); tick();
        issue_en = 1'b0;
        we = 1'b1; waddr = 5'd6; wdata = 32'h66;
        cancel_en = 1'b1; cancel_rd = 5'd6;
        tick();
        we = 1'b0; cancel_en = 1'b0;
        set_raddr(5'd6, 5'd0, 5'd0);
        settle();
        check("dec2_rbusy0", 32'(rbusy[0]), 32'd0);
        check("dec2_sb_err", 32'(sb_err), 32'd0);

        // ---- reset overrides same-cycle write and issue ----
        issue_en = 1'b1; issue_rd = 5'd5;
        tick(); tick(); tick();
        issue_en = 1'b0;
        we = 1'b1; waddr = 5'd5; wdata = 32'h77;
        tick();
        we = 1'b0;
        set_raddr(5'd5, 5'd0, 5'd0);
        settle();
        check("pre_rst_rdata0", rdata[31:0], 32'h77);
        check("pre_rst_rbusy0", 32'(rbusy[0]), 32'd1);
        reset = 1'b1; we = 1'b1; waddr = 5'd5; wdata = 32'h55;
        issue_en = 1'b1; issue_rd = 5'd5;
        tick();
        reset = 1'b0; we = 1'b0; issue_en = 1'b0;
        settle();
        check("rst_ovr_rdata0", rdata[31:0], 32'h0);
        check("rst_ovr_rbusy0", 32'(rbusy[0]), 32'd0);
        check("rst_ovr_rzero0", 32'(rzero[0]), 32'd1);
        check("rst_ovr_sb_err", 32'(sb_err), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
